// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage; issues loads/stores, stalls while the bus is busy, aligns load data.
// Ports: clk, rst_n (sync, active-low); in (ex_mem_t); stall; out (mem_wb_t, registered); readdata (registered);
//        dmem_req/we/addr/be/wdata, dmem_rdata/ready (data bus); misaligned, bus_err (registered pulses).
// Optional: define MEM_STAGE_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES wait cycles.
package mem_stage_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] pcplus4;
  } ex_mem_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] aluresult;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic [31:0] pcplus4;
  } mem_wb_t;
endpackage

module mem_stage import mem_stage_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ex_mem_t     in,
  output logic        stall,
  output mem_wb_t     out,
  output logic [31:0] readdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        misaligned,
  output logic        bus_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  state_t      r_state, w_next;
  ex_mem_t     r_lat, w_cur;
  logic        w_wait, w_mem, w_aligned, w_access, w_mis, w_timeout;
  logic [1:0]  w_off;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_load;
  // In WAIT the stage works from the latched instruction so the bus sees stable values.
  always_comb begin
    w_wait    = r_state == WAIT;
    w_cur     = w_wait ? r_lat : in;
    w_off     = w_cur.aluresult[1:0];
    w_mem     = rst_n & w_cur.valid & (w_cur.memread | w_cur.memwrite);
    w_aligned = w_cur.funct3[1:0] == 2'b10 ? w_off == 2'b00 :
                w_cur.funct3[1:0] == 2'b01 ? ~w_off[0] : 1'b1;
    w_access  = w_mem & w_aligned;
    w_mis     = w_mem & ~w_aligned;
    dmem_req  = w_access & ~w_timeout;
    stall     = dmem_req & ~dmem_ready;
    w_next    = stall ? WAIT : IDLE;
    dmem_we   = dmem_req & w_cur.memwrite;
    dmem_addr = {w_cur.aluresult[31:2], 2'b00};
    dmem_be   = w_cur.funct3[1:0] == 2'b00 ? 4'b0001 << w_off :
                w_cur.funct3[1:0] == 2'b01 ? 4'b0011 << w_off : 4'b1111;
    dmem_wdata = w_cur.funct3[1:0] == 2'b00 ? {4{w_cur.writedata[7:0]}} :
                 w_cur.funct3[1:0] == 2'b01 ? {2{w_cur.writedata[15:0]}} : w_cur.writedata;
    w_b = dmem_rdata[{w_off, 3'b000} +: 8];
    w_h = dmem_rdata[{w_off[1], 4'b0000} +: 16];
    case (w_cur.funct3)
      3'b000:  w_load = {{24{w_b[7]}}, w_b};
      3'b001:  w_load = {{16{w_h[15]}}, w_h};
      3'b010:  w_load = dmem_rdata;
      3'b100:  w_load = {24'd0, w_b};
      3'b101:  w_load = {16'd0, w_h};
      default: w_load = '0;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lat      <= '0;
      out        <= '0;
      readdata   <= '0;
      misaligned <= 1'b0;
    end else begin
      r_state    <= w_next;
      if (!w_wait) r_lat <= in;
      misaligned <= w_mis;
      if (stall) begin
        out      <= '0;
        readdata <= '0;
      end else begin
        out      <= '{w_cur.valid, w_cur.aluresult, w_cur.rd, w_cur.regwrite & ~w_mis & ~w_timeout,
                      w_cur.resultsrc, w_cur.pcplus4};
        readdata <= w_access & w_cur.memread & ~w_timeout ? w_load : '0;
      end
    end
`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  // r_cnt counts completed WAIT cycles; abort once the full budget has elapsed without ready.
  assign w_timeout = w_wait & ~dmem_ready & (r_cnt == CW'(TIMEOUT_CYCLES));
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_cnt   <= '0;
      bus_err <= 1'b0;
    end else begin
      r_cnt   <= w_wait ? r_cnt + 1'b1 : '0;
      bus_err <= w_timeout;
    end
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven, directed and randomized checks of mem_stage against a behavioural model.
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  ex_mem_t     in_s;
  mem_wb_t     out_s;
  logic        stall, dmem_req, dmem_we, dmem_ready, misaligned, bus_err;
  logic [31:0] readdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  int          n_chk = 0, n_fail = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_s), .stall(stall), .out(out_s), .readdata(readdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    ex_mem_t     x;
    logic [31:0] rdata;
    int          waits;
    logic        acc, mis;
    logic [3:0]  be;
    logic [31:0] wdata, rd;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ex_mem_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    ex_mem_t x = '0;
    x.valid = 1'b1; x.aluresult = a; x.writedata = wd; x.rd = 5'd9; x.regwrite = ~st;
    x.resultsrc = ld ? 2'b01 : 2'b00; x.memread = ld; x.memwrite = st; x.funct3 = f3;
    x.pcplus4 = a ^ 32'h0000_1000;
    return x;
  endfunction

  // Reference: access size in bytes, byte offset, lane arithmetic.
  function automatic void model(input ex_mem_t x, input logic [31:0] rdata, output logic acc,
                                output logic mis, output logic [3:0] be, output logic [31:0] wdata,
                                output logic [31:0] rd);
    int          sz  = x.funct3[1:0] == 2'd0 ? 1 : x.funct3[1:0] == 2'd1 ? 2 : 4;
    int          off = int'(x.aluresult % 4);
    logic [31:0] v   = rdata >> (8 * off);
    logic        mem = x.valid && (x.memread || x.memwrite);
    logic [31:0] msk = sz == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 1;
    mis   = mem && (off % sz != 0);
    acc   = mem && !mis;
    be    = 4'(((1 << sz) - 1) << off);
    wdata = (x.writedata & msk) * (sz == 1 ? 32'h0101_0101 : sz == 2 ? 32'h0001_0001 : 32'd1);
    case (x.funct3)
      3'd0:    rd = 32'($signed(v[7:0]));
      3'd1:    rd = 32'($signed(v[15:0]));
      3'd2:    rd = rdata;
      3'd4:    rd = v & 32'hFF;
      3'd5:    rd = v & 32'hFFFF;
      default: rd = 32'd0;
    endcase
    if (!(acc && x.memread)) rd = 32'd0;
  endfunction

  task automatic txn(input ex_mem_t x, input logic [31:0] rdata, input int waits, input logic acc,
                     input logic mis, input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] rd);
    mem_wb_t eo;
    int n;
    eo = '{x.valid, x.aluresult, x.rd, x.regwrite & ~mis, x.resultsrc, x.pcplus4};
    n = acc ? waits : 0;
    in_s = x;
    dmem_rdata = rdata;
    for (int c = 0; c <= n; c++) begin
      dmem_ready = (c == n);
      @(negedge clk);
      chk("dmem_req", dmem_req, acc);
      chk("stall", stall, c < n);
      if (acc) begin
        chk("dmem_addr", dmem_addr, x.aluresult & ~32'd3);
        chk("dmem_be", dmem_be, be);
        chk("dmem_we", dmem_we, x.memwrite);
        if (x.memwrite) chk("dmem_wdata", dmem_wdata, wdata);
      end
      @(posedge clk); #1;
      if (c < n) begin
        chk("bubble_out", out_s, '0);
        chk("bubble_readdata", readdata, '0);
      end else begin
        chk("out", out_s, eo);
        chk("readdata", readdata, rd);
        chk("misaligned", misaligned, mis);
        chk("bus_err", bus_err, 1'b0);
      end
    end
  endtask

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  vec_t tbl [12];

  initial begin
    tbl[0]  = '{mk(1, 0, 3'd0, 32'h103, 0), 32'h80FF_1234, 0, 1, 0, 4'b1000, 0, 32'hFFFF_FF80};
    tbl[1]  = '{mk(0, 1, 3'd1, 32'h202, 32'h0000_ABCD), 0, 0, 1, 0, 4'b1100, 32'hABCD_ABCD, 0};
    tbl[2]  = '{mk(1, 0, 3'd2, 32'h100, 0), 32'hDEAD_BEEF, 3, 1, 0, 4'b1111, 0, 32'hDEAD_BEEF};
    tbl[3]  = '{mk(1, 0, 3'd2, 32'h102, 0), 32'h5555_5555, 0, 0, 1, 4'b0000, 0, 0};
    tbl[4]  = '{mk(1, 0, 3'd4, 32'h101, 0), 32'h1234_8055, 1, 1, 0, 4'b0010, 0, 32'h0000_0080};
    tbl[5]  = '{mk(1, 0, 3'd5, 32'h106, 0), 32'h9ABC_1234, 0, 1, 0, 4'b1100, 0, 32'h0000_9ABC};
    tbl[6]  = '{mk(1, 0, 3'd1, 32'h106, 0), 32'h9ABC_1234, 2, 1, 0, 4'b1100, 0, 32'hFFFF_9ABC};
    tbl[7]  = '{mk(0, 1, 3'd0, 32'h301, 32'h1234_5678), 0, 2, 1, 0, 4'b0010, 32'h7878_7878, 0};
    tbl[8]  = '{mk(0, 0, 3'd0, 32'h040, 0), 32'hFFFF_FFFF, 0, 0, 0, 4'b0000, 0, 0};
    tbl[9]  = '{mk(0, 1, 3'd1, 32'h201, 32'h1234), 0, 0, 0, 1, 4'b0000, 0, 0};
    tbl[10] = '{mk(0, 1, 3'd2, 32'h40C, 32'h1122_3344), 0, 1, 1, 0, 4'b1111, 32'h1122_3344, 0};
    tbl[11] = '{mk(1, 0, 3'd0, 32'h000, 0), 32'h0000_007F, 0, 1, 0, 4'b0001, 0, 32'h0000_007F};

    in_s = '0; dmem_ready = 1'b0; dmem_rdata = '0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", out_s, '0);
    chk("reset_readdata", readdata, '0);
    chk("reset_misaligned", misaligned, 1'b0);
    chk("reset_bus_err", bus_err, 1'b0);
    chk("reset_req", dmem_req, 1'b0);
    chk("reset_stall", stall, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) txn(tbl[i].x, tbl[i].rdata, tbl[i].waits, tbl[i].acc, tbl[i].mis, tbl[i].be,
                         tbl[i].wdata, tbl[i].rd);

    // Reset arriving while an access is outstanding drops it.
    in_s = mk(1, 0, 3'd2, 32'h500, 0);
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_req", dmem_req, 1'b1);
    chk("wait_stall", stall, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstwait_req", dmem_req, 1'b0);
    chk("rstwait_stall", stall, 1'b0);
    chk("rstwait_out", out_s, '0);
    chk("rstwait_readdata", readdata, '0);
    in_s = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(tbl[0].x, tbl[0].rdata, 0, 1, 0, 4'b1000, 0, 32'hFFFF_FF80);

`ifdef MEM_STAGE_TIMEOUT_EN
    begin : timeout_seq
      int sc = 0;
      in_s = mk(1, 0, 3'd2, 32'h600, 0);
      dmem_ready = 1'b0;
      @(negedge clk);
      while (stall && sc < 40) begin
        sc++;
        @(negedge clk);
      end
      chk("timeout_stall_cycles", sc, 5);
      chk("timeout_req", dmem_req, 1'b0);
      @(posedge clk); #1;
      chk("timeout_regwrite", out_s.regwrite, 1'b0);
      chk("timeout_readdata", readdata, '0);
      chk("timeout_bus_err", bus_err, 1'b1);
      in_s = '0;
      @(posedge clk); #1;
      chk("timeout_bus_err_pulse", bus_err, 1'b0);
    end
`endif

    for (int i = 0; i < 150; i++) begin
      int          op;
      logic [2:0]  f3;
      ex_mem_t     x;
      logic [31:0] rdata, wd, rd;
      logic        acc, mis;
      logic [3:0]  be;
      op = $urandom_range(2);
      f3 = op == 0 ? ld_f3[$urandom_range(4)] : 3'($urandom_range(2));
      x = mk(op == 0, op == 1, f3, $urandom & 32'h0000_0FFF, $urandom);
      if (op == 2 && $urandom_range(1) == 1) x.valid = 1'b0;
      rdata = $urandom;
      model(x, rdata, acc, mis, be, wd, rd);
      txn(x, rdata, $urandom_range(3), acc, mis, be, wd, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage between the EX/MEM register and wb_stage. It issues loads and stores to the data-memory bus with a req/ready handshake and stalls the front of the pipeline while an access is outstanding. It aligns and sign-extends load data and registers the mem_wb_t bundle plus load data for wb_stage. It also detects misaligned accesses and, optionally, bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, cycles dmem_ready may stay low before an access is aborted (used only with MEM_STAGE_TIMEOUT_EN).

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; synchronous, active-low
in  input  ex_mem_t  fields: valid, aluresult[31:0], writedata[31:0], rd[4:0], regwrite, resultsrc[1:0], memread, memwrite, funct3[2:0], pcplus4[31:0]
stall  output  1  high while an access is incomplete; upstream holds `in` stable
out  output  mem_wb_t  registered bundle to wb_stage
readdata  output  32  registered aligned/extended load data to wb_stage
dmem_req  output  1  bus request
dmem_we  output  1  1 = store
dmem_addr  output  32  {addr[31:2],2'b00}
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_rdata  input  32  load data, valid in the cycle dmem_ready=1
dmem_ready  input  1  access completes in this cycle
misaligned  output  1  registered 1-cycle pulse, aligned with `out`
bus_err  output  1  registered 1-cycle pulse (tied 0 without the macro)

Behaviour:
- Reset (rst_n=0 at edge): FSM=IDLE; out all zero (regwrite=0); readdata=0; misaligned=0; bus_err=0; dmem_req=0; timeout counter=0. Reset overrides an outstanding access; the aborted request is dropped.
- Access = in.valid & (memread | memwrite) & aligned.
- Alignment: LW/SW need addr[1:0]=00. LH/LHU/SH need addr[0]=0. Byte accesses are always aligned.
- FSM states: IDLE, WAIT.
- IDLE, access present: dmem_req=1 combinationally from in.
  - dmem_ready=1 same cycle: zero-wait completion; out/readdata captured at edge; stay IDLE.
  - dmem_ready=0: stall=1; latch addr/be/wdata/we/funct3 and the mem_wb fields; go to WAIT.
- WAIT: dmem_req=1 driven from latched values; stall=1.
  - dmem_ready=1: stall=0; capture; go to IDLE.
- stall = (IDLE & access & ~dmem_ready) | (WAIT & ~dmem_ready).
- out update rule: on every non-stalled edge, out <= in fields (or latched fields on WAIT completion). On stalled edges, out <= bubble (regwrite=0, all other fields 0).
- Non-memory instruction: zero-cycle pass-through register; readdata=0.
- Stores: SB be=0001<<a[1:0], wdata={4{wd[7:0]}}. SH be=0011<<a[1:0], wdata={2{wd[15:0]}}. SW be=1111, wdata=wd.
- Loads: loads request be the same way. Extraction from dmem_rdata by byte offset: LB/LH sign-extend; LBU/LHU zero-extend; LW direct. Undefined funct3 gives readdata=0.
- Misaligned: no dmem_req; no stall. out captured with regwrite forced 0; misaligned=1 for that one output cycle.
- Simultaneous dmem_ready and new access in WAIT: the new access is not presented, since upstream is stalled; it issues next cycle from IDLE.
- dmem_req never drops while waiting; the address is stable until ready.

Optional Feature:
Macro: MEM_STAGE_TIMEOUT_EN.
- Defined: the counter increments every WAIT cycle. When it reaches TIMEOUT_CYCLES with dmem_ready still 0:
  - the access is aborted: dmem_req deasserts, FSM goes to IDLE, stall drops;
  - out is captured with regwrite=0 and readdata=0;
  - bus_err pulses 1 cycle.
  - The counter clears on entry to IDLE.
- Undefined: no counter; WAIT persists indefinitely; bus_err tied 0.

Test Plan:
- LB, aluresult=0x103, dmem_rdata=0x80FF_1234, ready immediate -> dmem_be=1000, readdata=0xFFFF_FF80 next cycle, stall never high.
- SH, aluresult=0x202, writedata=0x0000_ABCD -> dmem_addr=0x200, dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1.
- LW, 3 wait cycles -> stall high exactly 3 cycles, dmem_addr stable, out bubbles (regwrite=0) for 3 edges, then regwrite=1 with readdata=dmem_rdata.
- LW at aluresult=0x102 -> no dmem_req, misaligned=1 one cycle, out.regwrite=0.
- rst_n=0 during WAIT -> next edge: dmem_req=0, stall=0, out zero, FSM IDLE.
- With MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready held 0 -> stall drops after 4 WAIT cycles, bus_err pulses, readdata=0, regwrite=0.
